// File: rtl/seq_arbiter.sv
// rtl/seq_arbiter.sv - round-robin burst server for a(k)=a(k-2)+a(k-3)
// Each grant restarts the term engine at a(0) and streams len terms tagged with the winner id.
module seq_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_id,
  output logic                       out_last,
  output logic                       out_ovf,
  output logic                       busy
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, GRANT, STREAM} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  k_q, k_d;
  logic [DATA_W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic              fx_q, fx_d, fy_q, fy_d, fz_q, fz_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic              out_last_q, out_last_d;
  logic              out_ovf_q, out_ovf_d;

  logic [ID_W-1:0]   win_id;
  logic              win_found;
  int                idx;
  logic [DATA_W:0]   sum;

  assign sum = {1'b0, x_q} + {1'b0, y_q};

  // First requesting index at or after the priority pointer, wrapping.
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr_q) + off) % NUM_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    len_d       = len_q;
    k_d         = k_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    fx_d        = fx_q;
    fy_d        = fy_q;
    fz_d        = fz_q;
    req_ready_d = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gid_d               = win_id;
          len_d               = req_len[int'(win_id)*LEN_W +: LEN_W];
          ptr_d               = ID_W'((int'(win_id) + 1) % NUM_REQ);
          k_d                 = '0;
          x_d                 = '0;
          y_d                 = DATA_W'(1);
          z_d                 = DATA_W'(1);
          fx_d                = 1'b0;
          fy_d                = 1'b0;
          fz_d                = 1'b0;
          req_ready_d[win_id] = 1'b1;
          out_ovf_d           = 1'b0;
          state_d             = GRANT;
        end
      end
      GRANT: begin
        if (len_q == '0) begin
          state_d = IDLE;
        end else begin
          state_d     = STREAM;
          out_valid_d = 1'b1;
          out_data_d  = x_q;
          out_id_d    = gid_q;
          out_last_d  = (len_q == LEN_W'(1));
          out_ovf_d   = fx_q;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            // y becomes the presented term; the engine runs two terms ahead.
            x_d        = y_q;
            y_d        = z_q;
            z_d        = sum[DATA_W-1:0];
            fx_d       = fy_q;
            fy_d       = fz_q;
            fz_d       = sum[DATA_W] | fx_q | fy_q;
            k_d        = k_q + LEN_W'(1);
            out_data_d = y_q;
            out_ovf_d  = out_ovf_q | fy_q;
            out_last_d = (k_d == len_q - LEN_W'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gid_q       <= '0;
      len_q       <= '0;
      k_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      fx_q        <= 1'b0;
      fy_q        <= 1'b0;
      fz_q        <= 1'b0;
      req_ready_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gid_q       <= gid_d;
      len_q       <= len_d;
      k_q         <= k_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      fx_q        <= fx_d;
      fy_q        <= fy_d;
      fz_q        <= fz_d;
      req_ready_q <= req_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign req_ready = req_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_last  = out_last_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_seq_arbiter.sv
// tb/tb_seq_arbiter.sv - scoreboard bench for seq_arbiter
// Requests go in as rounds; expected grants and terms are queued at issue time and checked by a monitor.
module tb_seq_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int LW = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*LW-1:0]  req_len;
  logic [NR-1:0]     req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_id;
  logic              out_last;
  logic              out_ovf;
  logic              busy;

  seq_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_len(req_len),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .out_last(out_last),
    .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int id; int len;} grant_t;
  typedef struct {int id; longint data; bit last; bit ovf;} term_t;

  grant_t        gq[$];
  term_t         tq[$];
  bit            pat[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            mdl_ptr = 0;
  int            rdy_mode = 0;
  int            term_cnt = 0;
  bit            checking = 0;
  bit            stall_prev = 0;
  bit            first_pend = 0;
  int            first_len = 0;
  logic [NR-1:0] rr_q = '0;
  logic [DW-1:0] h_data;
  logic [1:0]    h_id;
  logic          h_last, h_ovf;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // True values saturate at 2^DW to decide overflow; residues give the presented data.
  task automatic push_burst(input int id, input int len);
    longint cap = longint'(1) << DW;
    longint sat[$];
    longint md[$];
    bit     ov = 0;
    term_t  t;
    for (int k = 0; k < len; k++) begin
      if (k < 3) begin
        sat.push_back((k == 0) ? 0 : 1);
        md.push_back((k == 0) ? 0 : 1);
      end else begin
        longint s;
        s = sat[k-2] + sat[k-3];
        sat.push_back((s > cap) ? cap : s);
        md.push_back((md[k-2] + md[k-3]) % cap);
      end
      ov     = ov | (sat[k] >= cap);
      t.id   = id;
      t.data = md[k];
      t.last = (k == len - 1);
      t.ovf  = ov;
      tq.push_back(t);
    end
  endtask

  task automatic launch(input logic [3:0] mask, input int l0, input int l1, input int l2, input int l3);
    int     lens[4];
    int     last;
    grant_t g;
    lens = '{l0, l1, l2, l3};
    last = mdl_ptr;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) req_len[i*LW +: LW] = LW'(lens[i]);
    req_valid = mask;
    term_cnt  = 0;
    for (int off = 0; off < NR; off++) begin
      int i;
      i = (mdl_ptr + off) % NR;
      if (mask[i]) begin
        g.id  = i;
        g.len = lens[i];
        gq.push_back(g);
        push_burst(i, lens[i]);
        last = i;
      end
    end
    mdl_ptr = (last + 1) % NR;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(req_valid == '0 && !busy && gq.size() == 0 && tq.size() == 0) && t < 3000);
    if (t >= 3000) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: got pending grants %0d terms %0d expected 0 0", gq.size(), tq.size());
      gq.delete();
      tq.delete();
      req_valid = '0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 0);
    chk({tag, "_out_valid"}, 64'(out_valid), 0);
    chk({tag, "_out_data"}, 64'(out_data), 0);
    chk({tag, "_out_id"}, 64'(out_id), 0);
    chk({tag, "_out_last"}, 64'(out_last), 0);
    chk({tag, "_out_ovf"}, 64'(out_ovf), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
      else if (out_valid && pat.size() > 0) out_ready = pat.pop_front();
      else out_ready = 1'b1;
      req_valid = req_valid & ~rr_q;
    end
  end

  always @(negedge clk) begin
    int    gi;
    term_t e;
    grant_t g;
    rr_q = req_ready;
    if (checking && !reset) begin
      if (first_pend) begin
        if (first_len == 0) begin
          chk("len0_busy_after_grant", 64'(busy), 0);
          chk("len0_no_valid", 64'(out_valid), 0);
        end else begin
          chk("first_term_latency", 64'(out_valid), 1);
        end
        first_pend = 0;
      end
      if (req_ready != '0) begin
        chk("grant_onehot", 64'($countones(req_ready)), 1);
        chk("busy_in_grant", 64'(busy), 1);
        gi = 0;
        for (int i = 0; i < NR; i++) if (req_ready[i]) gi = i;
        if (gq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_grant: got requester %0d expected none", gi);
        end else begin
          g = gq.pop_front();
          chk("grant_id", 64'(gi), 64'(g.id));
          first_pend = 1;
          first_len  = g.len;
        end
      end
      if (out_valid) begin
        if (stall_prev) begin
          chk("stall_data", 64'(out_data), 64'(h_data));
          chk("stall_id", 64'(out_id), 64'(h_id));
          chk("stall_last", 64'(out_last), 64'(h_last));
          chk("stall_ovf", 64'(out_ovf), 64'(h_ovf));
        end
        if (out_ready) begin
          stall_prev = 0;
          term_cnt++;
          if (tq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_term: got data %0d expected no term", out_data);
          end else begin
            e = tq.pop_front();
            chk("term_data", 64'(out_data), 64'(e.data));
            chk("term_id", 64'(out_id), 64'(e.id));
            chk("term_last", 64'(out_last), 64'(e.last));
            chk("term_ovf", 64'(out_ovf), 64'(e.ovf));
          end
        end else begin
          stall_prev = 1;
          h_data = out_data;
          h_id   = out_id;
          h_last = out_last;
          h_ovf  = out_ovf;
        end
      end else begin
        stall_prev = 0;
        chk("last_low_when_idle", 64'(out_last), 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    reset     = 1'b1;
    req_valid = '0;
    req_len   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset    = 1'b0;
    checking = 1;

    launch(4'b0001, 8, 0, 0, 0);
    wait_idle();
    launch(4'b1010, 0, 2, 0, 2);
    wait_idle();
    launch(4'b1111, 2, 2, 2, 2);
    wait_idle();

    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    rdy_mode = 2;
    launch(4'b0001, 3, 0, 0, 0);
    wait_idle();
    rdy_mode = 0;

    launch(4'b0100, 0, 0, 0, 0);
    wait_idle();
    launch(4'b0001, 24, 0, 0, 0);
    wait_idle();
    launch(4'b0010, 0, 2, 0, 0);
    wait_idle();

    rdy_mode = 1;
    for (int r = 0; r < 40; r++) begin
      launch(4'($urandom_range(1, 15)), $urandom_range(0, 30), $urandom_range(0, 30),
             $urandom_range(0, 30), $urandom_range(0, 30));
      wait_idle();
    end

    rdy_mode = 0;
    launch(4'b0001, 10, 0, 0, 0);
    t = 0;
    while (term_cnt < 3 && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("third_term_seen", 64'(term_cnt >= 3), 1);
    #2;
    checking = 0;
    reset    = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    gq.delete();
    tq.delete();
    req_valid  = '0;
    stall_prev = 0;
    first_pend = 0;
    mdl_ptr    = 0;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    checking = 1;
    launch(4'b1001, 3, 0, 0, 3);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
